// File: rtl/sn_to_bn.sv
// ---------------------------------------------------------------------------
// sn_to_bn -- stochastic-number to binary-number converter.
//
// Counts the 1-bits of LANES parallel stochastic bit streams over one
// conversion window and presents the per-lane counts plus the window
// length with a valid/ready handshake.
//
// A window opens on a start pulse in IDLE. Qualified bits (i_isgen=1) are
// accumulated until either WIN_LEN samples have been taken or the
// qualifier drops after at least one sample. The result is then held
// until the consumer takes it (i_ready) or the window is aborted
// (i_stop_sn2bn).
//
// Parameters:
//   LANES    number of stochastic lanes decoded in parallel
//   WIN_LEN  maximum number of qualified bits per window
//   CNT_W    width of every count; 2**CNT_W must exceed WIN_LEN
//
// Ports:
//   i_clk_sn2bn    clock, rising edge
//   i_rst_sn2bn    asynchronous active-low reset
//   i_start_sn2bn  single-cycle pulse, opens a window (IDLE only)
//   i_stop_sn2bn   abort; discards the window or the held result
//   i_isgen        qualifier for i_sn_bit
//   i_sn_bit       one stochastic bit per lane
//   i_ready        downstream accepts the held result
//   o_busy         high while accumulating or holding a result
//   o_valid        high while a result is held
//   o_bn           per-lane count of 1-bits (lane n in o_bn[n])
//   o_len          number of qualified bits in the window
// ---------------------------------------------------------------------------
module sn_to_bn #(
  parameter int LANES   = 4,
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic                         i_clk_sn2bn,
  input  logic                         i_rst_sn2bn,
  input  logic                         i_start_sn2bn,
  input  logic                         i_stop_sn2bn,
  input  logic                         i_isgen,
  input  logic [LANES-1:0]             i_sn_bit,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic                         o_valid,
  output logic [LANES-1:0][CNT_W-1:0]  o_bn,
  output logic [CNT_W-1:0]             o_len
);

  localparam logic [CNT_W-1:0] WIN_LEN_C = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                       state_reg, state_next;
  logic [LANES-1:0][CNT_W-1:0]  lane_cnt_reg, lane_cnt_next;
  logic [LANES-1:0][CNT_W-1:0]  lane_sum;
  logic [CNT_W-1:0]             len_reg, len_next, len_inc;
  logic [LANES-1:0][CNT_W-1:0]  bn_reg, bn_next;
  logic [CNT_W-1:0]             olen_reg, olen_next;

  // Per-lane count including the bit presented this cycle; used both for
  // accumulation and for the final load when the window fills up, so the
  // completing sample is never lost.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_sum[gi] = lane_cnt_reg[gi] + {{(CNT_W-1){1'b0}}, i_sn_bit[gi]};
    end
  endgenerate

  assign len_inc = len_reg + ONE_C;

  always_comb begin
    state_next    = state_reg;
    lane_cnt_next = lane_cnt_reg;
    len_next      = len_reg;
    bn_next       = bn_reg;
    olen_next     = olen_reg;

    case (state_reg)
      ST_IDLE: begin
        // Stop has priority over a simultaneous start.
        if (i_start_sn2bn && !i_stop_sn2bn) begin
          lane_cnt_next = '0;
          len_next      = '0;
          state_next    = ST_ACC;
        end
      end

      ST_ACC: begin
        if (i_stop_sn2bn) begin
          // Abort wins even over a completing sample; partial counts are
          // simply left behind and cleared by the next start.
          state_next = ST_IDLE;
        end else if (i_isgen) begin
          lane_cnt_next = lane_sum;
          len_next      = len_inc;
          if (len_inc == WIN_LEN_C) begin
            bn_next    = lane_sum;
            olen_next  = len_inc;
            state_next = ST_HOLD;
          end
        end else if (len_reg != '0) begin
          // Qualifier dropped after at least one sample: early end.
          // A drop before the first sample is upstream latency and waits.
          bn_next    = lane_cnt_reg;
          olen_next  = len_reg;
          state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (i_ready || i_stop_sn2bn) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_sn2bn or negedge i_rst_sn2bn) begin
    if (!i_rst_sn2bn) begin
      state_reg    <= ST_IDLE;
      lane_cnt_reg <= '0;
      len_reg      <= '0;
      bn_reg       <= '0;
      olen_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      lane_cnt_reg <= lane_cnt_next;
      len_reg      <= len_next;
      bn_reg       <= bn_next;
      olen_reg     <= olen_next;
    end
  end

  // Status decodes straight from the state register; the odd encoding
  // reads as idle.
  assign o_busy  = (state_reg == ST_ACC) || (state_reg == ST_HOLD);
  assign o_valid = (state_reg == ST_HOLD);
  assign o_bn    = bn_reg;
  assign o_len   = olen_reg;

endmodule

// File: tb/tb_sn_to_bn.sv
// ---------------------------------------------------------------------------
// tb_sn_to_bn -- self-checking bench for sn_to_bn.
//
// Each scenario loads a per-cycle stimulus table (qualifier + lane bits),
// and run_stim derives the expected completion cycle, lane counts and
// length by walking that table with the window rules, then drives the DUT
// and compares cycle by cycle. Directed scenarios add fixed expectations.
// ---------------------------------------------------------------------------
module tb_sn_to_bn;
  localparam int LANES   = 4;
  localparam int WIN_LEN = 16;
  localparam int CNT_W   = 5;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        start = 1'b0;
  logic                        stop = 1'b0;
  logic                        isgen = 1'b0;
  logic                        ready = 1'b0;
  logic [LANES-1:0]            sn_bit = '0;
  logic                        busy;
  logic                        valid;
  logic [LANES-1:0][CNT_W-1:0] bn;
  logic [CNT_W-1:0]            len;

  int total = 0;
  int bad = 0;

  int               stim_n;
  bit               stim_isg [64];
  logic [LANES-1:0] stim_bits [64];

  logic [LANES-1:0][CNT_W-1:0] cap_bn;
  logic [CNT_W-1:0]            cap_len;

  sn_to_bn #(.LANES(LANES), .WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
    .i_clk_sn2bn  (clk),
    .i_rst_sn2bn  (rst_n),
    .i_start_sn2bn(start),
    .i_stop_sn2bn (stop),
    .i_isgen      (isgen),
    .i_sn_bit     (sn_bit),
    .i_ready      (ready),
    .o_busy       (busy),
    .o_valid      (valid),
    .o_bn         (bn),
    .o_len        (len)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one window from the stimulus table and check it end to end.
  task automatic run_stim(input string name, input int hold_cycles,
                          input bit start_in_hold, input bit exit_by_stop);
    int cnt;
    int end_idx;
    int ones [LANES];
    logic [CNT_W-1:0] exp_bn [LANES];
    logic [CNT_W-1:0] exp_len;
    cnt = 0;
    end_idx = -1;
    for (int l = 0; l < LANES; l++) ones[l] = 0;
    for (int i = 0; i < stim_n; i++) begin
      if (stim_isg[i]) begin
        for (int l = 0; l < LANES; l++) ones[l] += int'(stim_bits[i][l]);
        cnt++;
        if (cnt == WIN_LEN) begin
          end_idx = i;
          break;
        end
      end else if (cnt > 0) begin
        end_idx = i;
        break;
      end
    end
    for (int l = 0; l < LANES; l++) exp_bn[l] = CNT_W'(ones[l]);
    exp_len = CNT_W'(cnt);
    total++;
    if (end_idx < 0) begin
      bad++;
      $display("FAIL %s stimulus: window never completes (samples=%0d)", name, cnt);
      return;
    end

    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s start: busy=%0b expected 1", name, busy);
    end

    for (int i = 0; i <= end_idx; i++) begin
      isgen  = stim_isg[i];
      // Unqualified cycles carry random junk that must not be counted.
      sn_bit = stim_isg[i] ? stim_bits[i] : LANES'($urandom);
      step();
      if (i < end_idx) begin
        total++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL %s acc cycle %0d: valid=%0b busy=%0b expected valid=0 busy=1",
                   name, i, valid, busy);
        end
      end else begin
        cap_bn  = bn;
        cap_len = len;
        total++;
        if (valid !== 1'b1) begin
          bad++;
          $display("FAIL %s done valid: got %0b expected 1", name, valid);
        end
        total++;
        if (len !== exp_len) begin
          bad++;
          $display("FAIL %s o_len: got %0d expected %0d", name, len, exp_len);
        end
        for (int l = 0; l < LANES; l++) begin
          total++;
          if (bn[l] !== exp_bn[l]) begin
            bad++;
            $display("FAIL %s o_bn[%0d]: got %0d expected %0d", name, l, bn[l], exp_bn[l]);
          end
        end
      end
    end
    isgen = 1'b0;

    for (int h = 0; h < hold_cycles; h++) begin
      isgen  = 1'($urandom);
      sn_bit = LANES'($urandom);
      start  = start_in_hold && (h == 1);
      step();
      start = 1'b0;
      total++;
      if (valid !== 1'b1 || len !== exp_len || bn[0] !== exp_bn[0] ||
          bn[LANES-1] !== exp_bn[LANES-1]) begin
        bad++;
        $display("FAIL %s hold %0d: valid=%0b len=%0d bn0=%0d expected valid=1 len=%0d bn0=%0d",
                 name, h, valid, len, bn[0], exp_len, exp_bn[0]);
      end
    end
    isgen = 1'b0;

    if (exit_by_stop) stop = 1'b1;
    else ready = 1'b1;
    step();
    stop  = 1'b0;
    ready = 1'b0;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s release: valid=%0b busy=%0b expected 0 0", name, valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || bn !== '0 || len !== '0) begin
      bad++;
      $display("FAIL reset: busy=%0b valid=%0b bn=%h len=%0d expected all 0",
               busy, valid, bn, len);
    end
    #10;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_window();
    stim_n = 17;
    for (int i = 0; i < 16; i++) begin
      stim_isg[i] = 1'b1;
      stim_bits[i][0] = 1'b1;
      stim_bits[i][1] = 1'b0;
      stim_bits[i][2] = (i % 2 == 0);
      stim_bits[i][3] = (i % 4 == 0);
    end
    stim_isg[16] = 1'b0;
    stim_bits[16] = '0;
    run_stim("full_window", 1, 1'b0, 1'b0);
    total++;
    if (cap_bn[0] !== 5'd16 || cap_bn[1] !== 5'd0 || cap_bn[2] !== 5'd8 ||
        cap_bn[3] !== 5'd4 || cap_len !== 5'd16) begin
      bad++;
      $display("FAIL full_window const: bn={%0d,%0d,%0d,%0d} len=%0d expected {16,0,8,4} 16",
               cap_bn[0], cap_bn[1], cap_bn[2], cap_bn[3], cap_len);
    end
  endtask

  // Gaps can only precede the first sample; a gap after it ends the window.
  task automatic test_gapped();
    stim_n = 25;
    for (int i = 0; i < 8; i++) begin
      stim_isg[i] = 1'b0;
      stim_bits[i] = '0;
    end
    for (int i = 8; i < 24; i++) begin
      stim_isg[i] = 1'b1;
      stim_bits[i] = LANES'($urandom) | LANES'(1);
    end
    stim_isg[24] = 1'b0;
    stim_bits[24] = '0;
    run_stim("gapped", 0, 1'b0, 1'b0);
    total++;
    if (cap_bn[0] !== 5'd16 || cap_len !== 5'd16) begin
      bad++;
      $display("FAIL gapped const: bn0=%0d len=%0d expected 16 16", cap_bn[0], cap_len);
    end
  endtask

  task automatic test_early_end();
    stim_n = 11;
    for (int i = 0; i < 10; i++) begin
      stim_isg[i] = 1'b1;
      stim_bits[i] = LANES'($urandom) | LANES'(1);
    end
    stim_isg[10] = 1'b0;
    stim_bits[10] = '0;
    run_stim("early_end", 2, 1'b0, 1'b0);
    total++;
    if (cap_bn[0] !== 5'd10 || cap_len !== 5'd10) begin
      bad++;
      $display("FAIL early_end const: bn0=%0d len=%0d expected 10 10", cap_bn[0], cap_len);
    end
  endtask

  task automatic test_abort();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      isgen  = 1'b1;
      sn_bit = '1;
      stop   = (i == 6);
      step();
    end
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL abort: busy=%0b valid=%0b expected 0 0", busy, valid);
    end
    step();
    isgen = 1'b0;
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL abort later: valid=%0b expected 0", valid);
    end
    stim_n = 6;
    for (int i = 0; i < 5; i++) begin
      stim_isg[i] = 1'b1;
      stim_bits[i] = '1;
    end
    stim_isg[5] = 1'b0;
    stim_bits[5] = '0;
    run_stim("after_abort", 0, 1'b0, 1'b0);
    total++;
    if (cap_bn[0] !== 5'd5 || cap_bn[3] !== 5'd5 || cap_len !== 5'd5) begin
      bad++;
      $display("FAIL after_abort const: bn0=%0d bn3=%0d len=%0d expected 5 5 5",
               cap_bn[0], cap_bn[3], cap_len);
    end
  endtask

  task automatic test_backpressure();
    stim_n = 13;
    for (int i = 0; i < 12; i++) begin
      stim_isg[i] = 1'b1;
      stim_bits[i] = LANES'($urandom);
    end
    stim_isg[12] = 1'b0;
    stim_bits[12] = '0;
    run_stim("backpressure", 5, 1'b1, 1'b0);
  endtask

  task automatic test_stop_on_completion();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      isgen  = 1'b1;
      sn_bit = LANES'($urandom);
      stop   = (i == 15);
      step();
    end
    stop  = 1'b0;
    isgen = 1'b0;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stop_on_completion: valid=%0b busy=%0b expected 0 0", valid, busy);
    end
  endtask

  task automatic test_start_stop_same();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      isgen  = 1'b1;
      sn_bit = '1;
      step();
      total++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        bad++;
        $display("FAIL start_stop_same cycle %0d: busy=%0b valid=%0b expected 0 0",
                 i, busy, valid);
      end
    end
    isgen = 1'b0;
  endtask

  task automatic test_reset_mid_acc();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      isgen  = 1'b1;
      sn_bit = '1;
      step();
    end
    isgen = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || bn !== '0 || len !== '0) begin
      bad++;
      $display("FAIL reset_mid_acc: busy=%0b valid=%0b bn=%h len=%0d expected all 0",
               busy, valid, bn, len);
    end
    #2;
    rst_n = 1'b1;
    step();
    stim_n = 8;
    for (int i = 0; i < 7; i++) begin
      stim_isg[i] = 1'b1;
      stim_bits[i] = LANES'($urandom);
    end
    stim_isg[7] = 1'b0;
    stim_bits[7] = '0;
    run_stim("after_reset", 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int gap;
    int run;
    for (int t = 0; t < 40; t++) begin
      gap = int'($urandom_range(0, 4));
      run = int'($urandom_range(1, 24));
      stim_n = 0;
      for (int i = 0; i < gap; i++) begin
        stim_isg[stim_n] = 1'b0;
        stim_bits[stim_n] = LANES'($urandom);
        stim_n++;
      end
      for (int i = 0; i < run; i++) begin
        stim_isg[stim_n] = (i == 0) || ($urandom_range(0, 9) != 0);
        stim_bits[stim_n] = LANES'($urandom) & LANES'($urandom | 32'h5);
        stim_n++;
      end
      stim_isg[stim_n] = 1'b0;
      stim_bits[stim_n] = '0;
      stim_n++;
      run_stim($sformatf("random_%0d", t), int'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_gapped();
    test_early_end();
    test_abort();
    test_backpressure();
    test_stop_on_completion();
    test_start_stop_same();
    test_reset_mid_acc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
